// File: rtl/param_ram_if.sv
// Access bus of param_ram: the request fields from the controller, and the
// registered read data and status returned to it.
interface param_ram_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              cs;
  logic              wr;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] Din;
  logic              clr;
  logic [DATA_W-1:0] Dout;
  logic              Dvalid;
  logic              busy;

  modport master (output cs, wr, adr, Din, clr, input Dout, Dvalid, busy);
  modport slave  (input cs, wr, adr, Din, clr, output Dout, Dvalid, busy);
endinterface

// File: rtl/param_ram.sv
// Parametrised single-port synchronous RAM with registered read port and a
// clear engine that fills the whole array with CLR_VAL after reset or on request.
module param_ram #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 6,
  parameter int                 RDW_MODE = 0,
  parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
  input  logic        clock,
  input  logic        reset,
  param_ram_if.slave  bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              access;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [DATA_W-1:0] mem_din;

  logic [DATA_W-1:0] dout_q;
  logic              dvalid_q;
  logic              busy_q;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    access    = (state == ST_IDLE) && bus.cs && !bus.clr;
    mem_we    = 1'b0;
    mem_adr   = bus.adr;
    mem_din   = bus.Din;
    case (state)
      ST_INIT, ST_CLEAR: begin
        mem_we  = 1'b1;
        mem_adr = cnt;
        mem_din = CLR_VAL;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADR) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // A clear request takes priority and drops any access in the same cycle.
        if (bus.clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end else begin
          mem_we = bus.cs && bus.wr;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      cnt      <= '0;
      busy_q   <= 1'b1;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy_q   <= (state_nxt != ST_IDLE);
      dvalid_q <= access;
      if (access) begin
        // mem is read before this edge's write lands, so the default is old data.
        if (RDW_MODE != 0 && bus.wr) dout_q <= bus.Din;
        else                         dout_q <= mem[bus.adr];
      end
    end
  end

  // NOTE: the array has no reset; the clear engine initialises it after every reset instead.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_adr] <= mem_din;
  end

  assign bus.Dout   = dout_q;
  assign bus.Dvalid = dvalid_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_param_ram.sv
// Directed bench for param_ram: old-data and write-through instances at 8x64,
// plus a 16x16 instance with a non-zero clear value, checked against a scoreboard.
module tb_param_ram;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  param_ram_if #(.DATA_W(8),  .ADDR_W(6)) ia ();
  param_ram_if #(.DATA_W(8),  .ADDR_W(6)) ib ();
  param_ram_if #(.DATA_W(16), .ADDR_W(4)) ic ();

  param_ram #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(0), .CLR_VAL(8'h00))
    dut_a (.clock(clock), .reset(reset), .bus(ia));
  param_ram #(.DATA_W(8), .ADDR_W(6), .RDW_MODE(1), .CLR_VAL(8'h00))
    dut_b (.clock(clock), .reset(reset), .bus(ib));
  param_ram #(.DATA_W(16), .ADDR_W(4), .RDW_MODE(0), .CLR_VAL(16'hBEEF))
    dut_c (.clock(clock), .reset(reset), .bus(ic));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] sb16[$];
  logic [7:0]  model [64];
  logic [15:0] model16 [16];
  logic [7:0]  held_a, held_b;
  logic        exp_busy;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model8();
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
  endtask

  // One cycle on both 8-bit instances; expected read data is queued at drive time.
  task automatic acc(input logic c, input logic w, input logic [5:0] a,
                     input logic [7:0] d, input logic cl);
    exp_t e;
    logic v;
    ia.cs = c; ia.wr = w; ia.adr = a; ia.Din = d; ia.clr = cl;
    ib.cs = c; ib.wr = w; ib.adr = a; ib.Din = d; ib.clr = cl;
    v = c && !cl && !exp_busy;
    if (v) begin
      e.a = model[a];
      e.b = w ? d : model[a];
      if (w) model[a] = d;
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    ia.cs = 1'b0; ia.clr = 1'b0;
    ib.cs = 1'b0; ib.clr = 1'b0;
    chk($sformatf("dvalid_a@%0d", a), ia.Dvalid, v);
    chk($sformatf("dvalid_b@%0d", a), ib.Dvalid, v);
    if (v && sb.size() > 0) begin
      e = sb.pop_front();
      held_a = e.a;
      held_b = e.b;
    end
    chk($sformatf("dout_a@%0d", a), ia.Dout, held_a);
    chk($sformatf("dout_b@%0d", a), ib.Dout, held_b);
  endtask

  task automatic acc16(input logic w, input logic [3:0] a, input logic [15:0] d);
    logic [15:0] e;
    ic.cs = 1'b1; ic.wr = w; ic.adr = a; ic.Din = d; ic.clr = 1'b0;
    sb16.push_back(model16[a]);
    if (w) model16[a] = d;
    @(posedge clock);
    #1;
    ic.cs = 1'b0;
    chk($sformatf("dvalid_16@%0d", a), ic.Dvalid, 1'b1);
    e = sb16.pop_front();
    chk($sformatf("dout_16@%0d", a), ic.Dout, e);
  endtask

  // Measures busy length while hammering ignored writes at the 8-bit instances.
  task automatic run_busy(input string tag, input bit with16);
    int na = 0, nb = 0, n16 = 0;
    exp_busy = 1'b1;
    for (int i = 0; i < 200 && (ia.busy || ib.busy || (with16 && ic.busy)); i++) begin
      if (ia.busy) na++;
      if (ib.busy) nb++;
      if (ic.busy) n16++;
      acc(1'b1, 1'b1, 6'(i), 8'h77, 1'b0);
    end
    exp_busy = 1'b0;
    chk({tag, "_busy_a"}, na, 64);
    chk({tag, "_busy_b"}, nb, 64);
    if (with16) chk({tag, "_busy_16"}, n16, 16);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout_a"},   ia.Dout,   8'h00);
    chk({tag, "_dvalid_a"}, ia.Dvalid, 1'b0);
    chk({tag, "_busy_a"},   ia.busy,   1'b1);
    chk({tag, "_dout_b"},   ib.Dout,   8'h00);
    chk({tag, "_dvalid_b"}, ib.Dvalid, 1'b0);
    chk({tag, "_busy_b"},   ib.busy,   1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

  initial begin
    reset = 1'b1;
    exp_busy = 1'b0;
    held_a = 8'h00;
    held_b = 8'h00;
    ia.cs = 0; ia.wr = 0; ia.adr = '0; ia.Din = '0; ia.clr = 0;
    ib.cs = 0; ib.wr = 0; ib.adr = '0; ib.Din = '0; ib.clr = 0;
    ic.cs = 0; ic.wr = 0; ic.adr = '0; ic.Din = '0; ic.clr = 0;
    clear_model8();
    for (int i = 0; i < 16; i++) model16[i] = 16'hBEEF;

    // Reset state, then init length for both geometries.
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("rst");
    chk("rst_dout_16", ic.Dout, 16'h0000);
    chk("rst_busy_16", ic.busy, 1'b1);
    reset = 1'b0;
    run_busy("init", 1'b1);

    // 16-bit instance: cleared to BEEF, write/read at the top address.
    for (int i = 0; i < 16; i++) acc16(1'b0, 4'(i), 16'h0000);
    acc16(1'b1, 4'd15, 16'h1234);
    acc16(1'b0, 4'd15, 16'h0000);

    // Reads after init.
    acc(1'b1, 1'b0, 6'd0,  8'h00, 1'b0);
    acc(1'b1, 1'b0, 6'd31, 8'h00, 1'b0);
    acc(1'b1, 1'b0, 6'd63, 8'h00, 1'b0);

    // Write, read back, then idle cycles hold Dout.
    acc(1'b1, 1'b1, 6'd5, 8'hA5, 1'b0);
    acc(1'b1, 1'b0, 6'd5, 8'h00, 1'b0);
    repeat (3) acc(1'b0, 1'b0, 6'd0, 8'h00, 1'b0);

    // Read-during-write in both modes.
    acc(1'b1, 1'b1, 6'd9, 8'h11, 1'b0);
    acc(1'b1, 1'b1, 6'd9, 8'h22, 1'b0);
    acc(1'b1, 1'b0, 6'd9, 8'h00, 1'b0);

    // Fill with address, clear with a colliding write, verify all cleared.
    for (int i = 0; i < 64; i++) acc(1'b1, 1'b1, 6'(i), 8'(i), 1'b0);
    acc(1'b1, 1'b1, 6'd3, 8'hFF, 1'b1);
    clear_model8();
    run_busy("clr", 1'b0);
    for (int i = 0; i < 64; i++) acc(1'b1, 1'b0, 6'(i), 8'h00, 1'b0);

    // Reset in the middle of a clear restarts the full sweep.
    for (int i = 0; i < 64; i++) acc(1'b1, 1'b1, 6'(i), ~8'(i), 1'b0);
    acc(1'b0, 1'b0, 6'd0, 8'h00, 1'b1);
    exp_busy = 1'b1;
    repeat (20) acc(1'b0, 1'b0, 6'd0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    held_a = 8'h00;
    held_b = 8'h00;
    clear_model8();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    run_busy("midrst", 1'b0);
    for (int i = 0; i < 64; i++) acc(1'b1, 1'b0, 6'(i), 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/param_ram.md
Name: param_ram

Overview:
Parametrised single-port synchronous RAM with chip select, replacing the fixed 64x8 memory in the processor datapath. Adds:
- configurable data/address width
- defined read-during-write mode
- a read-valid strobe
- a hardware clear engine that fills every location with a constant after reset or on request, with a busy flag so the controller can stall.

Parameters:
DATA_W, 8, data word width in bits (>=1)
ADDR_W, 6, address width; DEPTH = 2**ADDR_W words
RDW_MODE, 0, read-during-write result: 0 = old data, 1 = new data (write-through)
CLR_VAL, 0, DATA_W-bit value written to every word by the clear engine

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cs  input  1  chip select; access request this cycle
wr  input  1  1 = write, 0 = read (qualified by cs)
adr  input  ADDR_W  word address
Din  input  DATA_W  write data
clr  input  1  single-cycle request to clear whole array
Dout  output  DATA_W  registered read data
Dvalid  output  1  Dout updated by the access of the previous cycle
busy  output  1  clear engine active; accesses ignored

Behaviour:
- Reset, asynchronous and active-high: Dout=0, Dvalid=0, busy=1, clear counter=0, FSM=INIT. Array contents are not reset directly; INIT overwrites them.
- FSM states:
  - INIT: each cycle write CLR_VAL to mem[cnt], cnt++. When cnt==DEPTH-1 is written, go to IDLE next cycle. busy=1 throughout. Takes exactly DEPTH cycles after reset release.
  - IDLE: busy=0; normal accesses. clr=1 goes to CLEAR next cycle with cnt=0.
  - CLEAR: identical to INIT (DEPTH cycles, busy=1), then IDLE.
- busy is a registered output and equals (state != IDLE).
- While busy=1:
  - cs, wr, adr, Din and clr are ignored.
  - Dvalid=0 and Dout holds.
- Read (IDLE, cs=1, wr=0, clr=0): Dout <= mem[adr] at the edge. Dvalid=1 for the following cycle. Latency 1 cycle.
- Write (IDLE, cs=1, wr=1, clr=0): mem[adr] <= Din at the edge. Dvalid=1 next cycle, and Dout is loaded as follows:
  - RDW_MODE=0: Dout <= previous mem[adr].
  - RDW_MODE=1: Dout <= Din.
- Idle cycle (cs=0): Dout holds its last value (no high-Z); Dvalid=0 next cycle.
- Simultaneous clr=1 and cs=1 in IDLE: clr wins. The access is dropped; no write and no Dvalid.
- Clear counter is ADDR_W bits and terminates on the DEPTH-1 compare, not on overflow.
- Back-to-back accesses at full rate are allowed. A read of an address written on the previous cycle returns the new data.
- Reset asserted mid-INIT/CLEAR or mid-access: immediate return to reset values. The clear restarts from address 0 after release.
- Dout is not modified by clear-engine writes.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Reset, then release. busy=1 for exactly 64 cycles (defaults), then 0. Reading adr 0, 31 and 63 returns 8'h00 with Dvalid=1 one cycle after each cs.
2. Write 8'hA5 to adr 5, then read adr 5 next cycle -> Dout=8'hA5, Dvalid=1. With cs=0 for 3 cycles, Dout holds 8'hA5 and Dvalid=0.
3. Read-during-write with mem[9]=8'h11, write 8'h22 to adr 9:
   - RDW_MODE=0 -> Dout=8'h11
   - RDW_MODE=1 -> Dout=8'h22
   - Subsequent read -> 8'h22 in both modes.
4. Fill all 64 words with their address, then pulse clr together with cs=1, wr=1, adr=3, Din=8'hFF:
   - write dropped
   - busy=1 for 64 cycles
   - accesses during busy have no effect and Dvalid stays 0
   - afterwards every word reads CLR_VAL
5. Assert reset at clear cycle 20. Outputs go to reset values immediately. After release busy lasts a full 64 cycles and all words read CLR_VAL.
6. DATA_W=16, ADDR_W=4, CLR_VAL=16'hBEEF: busy for 16 cycles after reset, every word reads 16'hBEEF. Write and read back 16'h1234 at adr 15 (wrap boundary) -> 16'h1234.
